// File: rtl/kim1_display_keypad.sv
// kim1_display_keypad: decodes 6530 port B digit/row select, latches LED segments, debounces the key matrix
module kim1_display_keypad #(
  parameter int HOLD_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic        phi2,
  input  logic        rst_n,
  input  logic [7:0]  PAO,
  input  logic [7:0]  DDRA,
  input  logic [7:0]  PBO,
  input  logic [7:0]  DDRB,
  input  logic [20:0] key_raw,
  output logic [7:0]  PAI,
  output logic [41:0] digits,
  output logic [5:0]  digit_valid,
  output logic        frame_tick,
  output logic [20:0] key_db
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD    = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [7:0]    w_pb_eff;
  logic [3:0]    w_sel;
  logic [6:0]    w_seg;
  logic          w_same;
  logic          w_fire;
  logic [HW-1:0] w_stable_nxt;
  logic [5:0]    w_hit;
  logic [5:0]    w_expire;
  logic [3:0]    r_prev_sel;
  logic [6:0]    r_prev_seg;
  logic [HW-1:0] r_stable_cnt;
  logic [TW-1:0] r_to_cnt [6];
  logic [20:0]   r_sync1;
  logic [20:0]   r_key_s;
  logic [DW-1:0] r_db_cnt [21];
  // undriven port pins float high through the pull-ups; undriven segment pins read as off
  assign w_pb_eff = PBO | ~DDRB;
  assign w_sel    = w_pb_eff[4:1];
  assign w_seg    = PAO[6:0] & DDRA[6:0];
  always_comb begin
    w_same       = (w_sel == r_prev_sel) && (w_seg == r_prev_seg);
    w_stable_nxt = !w_same ? HW'(1) : (r_stable_cnt == HOLD) ? HOLD : r_stable_cnt + 1'b1;
    w_fire       = (w_stable_nxt == HOLD) && (!w_same || r_stable_cnt != HOLD) && (w_seg != 7'd0);
    for (int i = 0; i < 6; i++) begin
      w_hit[i]    = w_fire && (w_sel == 4'(i + 4));
      w_expire[i] = digit_valid[i] && (r_to_cnt[i] == TO_LAST);
    end
  end
  always_comb begin
    PAI = 8'hFF;
    for (int r = 0; r < 3; r++)
      if (w_sel == 4'(r)) PAI[6:0] = ~key_db[r*7 +: 7];
  end
  // a latch and an expiry on the same digit and edge resolve in favour of the latch
  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_sel   <= '0;
      r_prev_seg   <= '0;
      r_stable_cnt <= '0;
      frame_tick   <= 1'b0;
      digits       <= '0;
      digit_valid  <= '0;
      for (int i = 0; i < 6; i++) r_to_cnt[i] <= '0;
    end else begin
      r_prev_sel   <= w_sel;
      r_prev_seg   <= w_seg;
      r_stable_cnt <= w_stable_nxt;
      frame_tick   <= w_hit[5];
      for (int i = 0; i < 6; i++) begin
        if (w_hit[i]) begin
          digits[7*i +: 7] <= w_seg;
          digit_valid[i]   <= 1'b1;
          r_to_cnt[i]      <= '0;
        end else if (w_expire[i]) begin
          digits[7*i +: 7] <= '0;
          digit_valid[i]   <= 1'b0;
          r_to_cnt[i]      <= '0;
        end else if (digit_valid[i]) begin
          r_to_cnt[i] <= r_to_cnt[i] + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_key_s <= '0;
      key_db  <= '0;
      for (int b = 0; b < 21; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_key_s <= r_sync1;
      for (int b = 0; b < 21; b++) begin
        if (r_key_s[b] == key_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          key_db[b]   <= r_key_s[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_kim1_display_keypad.sv
// tb_kim1_display_keypad: directed and randomized checks of kim1_display_keypad against a sample-history model
module tb_kim1_display_keypad;
  localparam int HOLD = 4;
  localparam int TO_C = 32;
  localparam int DB_C = 3;
  logic        phi2 = 1'b0;
  logic        rst_n;
  logic [7:0]  PAO, DDRA, PBO, DDRB;
  logic [20:0] key_raw;
  logic [7:0]  PAI;
  logic [41:0] digits;
  logic [5:0]  digit_valid;
  logic        frame_tick;
  logic [20:0] key_db;
  int n_chk = 0;
  int n_err = 0;
  kim1_display_keypad #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO_C), .DEBOUNCE_CYCLES(DB_C)) dut (
    .phi2(phi2), .rst_n(rst_n), .PAO(PAO), .DDRA(DDRA), .PBO(PBO), .DDRB(DDRB),
    .key_raw(key_raw), .PAI(PAI), .digits(digits), .digit_valid(digit_valid),
    .frame_tick(frame_tick), .key_db(key_db)
  );
  always #5 phi2 = ~phi2;
  // reference model: keeps the raw (sel,seg) and key samples of recent edges and applies the rules directly
  logic [10:0] sh[$];
  logic [20:0] rh[$];
  logic [41:0] m_digits;
  logic [5:0]  m_val;
  logic        m_ft;
  logic [20:0] m_db;
  int          m_le[6];
  int          m_n;
  logic [7:0]  m_pb;
  logic [3:0]  m_sel;
  logic [6:0]  m_seg;
  bit          m_fire, m_flip;
  always @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      sh.delete();
      rh.delete();
      for (int k = 0; k < DB_C + 1; k++) rh.push_back(21'd0);
      m_digits = '0; m_val = '0; m_ft = 1'b0; m_db = '0; m_n = 0;
      for (int d = 0; d < 6; d++) m_le[d] = 0;
    end else begin
      m_n++;
      m_pb  = PBO | ~DDRB;
      m_sel = m_pb[4:1];
      m_seg = PAO[6:0] & DDRA[6:0];
      sh.push_back({m_sel, m_seg});
      if (sh.size() > HOLD + 1) void'(sh.pop_front());
      m_fire = (sh.size() >= HOLD);
      for (int k = 1; k < HOLD; k++)
        if (sh.size() > k && sh[sh.size()-1-k] != sh[sh.size()-1]) m_fire = 0;
      if (sh.size() > HOLD && sh[0] == sh[sh.size()-1]) m_fire = 0;
      m_ft = 1'b0;
      for (int d = 0; d < 6; d++)
        if (m_val[d] && (m_n - m_le[d] == TO_C - 1)) begin
          m_val[d] = 1'b0;
          m_digits[7*d +: 7] = 7'd0;
        end
      if (m_fire && m_sel >= 4 && m_sel <= 9 && m_seg != 7'd0) begin
        m_digits[7*(m_sel-4) +: 7] = m_seg;
        m_val[m_sel-4] = 1'b1;
        m_le[m_sel-4] = m_n;
        m_ft = (m_sel == 4'd9);
      end
      rh.push_back(key_raw);
      if (rh.size() > DB_C + 2) void'(rh.pop_front());
      for (int b = 0; b < 21; b++) begin
        m_flip = 1;
        for (int k = 0; k < DB_C; k++)
          if (rh[rh.size()-3-k][b] == m_db[b]) m_flip = 0;
        if (m_flip) m_db[b] = ~m_db[b];
      end
    end
  end
  function automatic logic [7:0] exp_pai();
    logic [7:0] pb;
    int s;
    pb = PBO | ~DDRB;
    s = int'(pb[4:1]);
    exp_pai = 8'hFF;
    if (s < 3) exp_pai[6:0] = ~m_db[s*7 +: 7];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic check_all();
    chk("digits", 64'(digits), 64'(m_digits));
    chk("digit_valid", 64'(digit_valid), 64'(m_val));
    chk("frame_tick", 64'(frame_tick), 64'(m_ft));
    chk("key_db", 64'(key_db), 64'(m_db));
    chk("PAI", 64'(PAI), 64'(exp_pai()));
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge phi2);
      check_all();
    end
  endtask
  logic [7:0] seg_tab [6] = '{8'h00, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'hFF};
  initial begin
    int hold;
    int kb;
    rst_n = 1'b0; PAO = 8'h00; DDRA = 8'h00; PBO = 8'h00; DDRB = 8'h00; key_raw = '0;
    #1;
    chk("rst_digits", 64'(digits), 64'd0);
    chk("rst_valid", 64'(digit_valid), 64'd0);
    chk("rst_ft", 64'(frame_tick), 64'd0);
    chk("rst_key_db", 64'(key_db), 64'd0);
    chk("rst_pai", 64'(PAI), 64'hFF);
    repeat (2) @(negedge phi2);
    rst_n = 1'b1;
    DDRA = 8'hFF; DDRB = 8'h1E; PBO = 8'h08; PAO = 8'h3F;
    tick(3);
    chk("latch_early", 64'(digit_valid[0]), 64'd0);
    tick(1);
    chk("latch_d0", 64'(digits[6:0]), 64'h3F);
    chk("latch_v0", 64'(digit_valid[0]), 64'd1);
    tick(10);
    chk("hold_v0", 64'(digit_valid[0]), 64'd1);
    PBO = 8'h12; PAO = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("blank_ft", 64'(frame_tick), 64'd0);
    end
    chk("blank_v5", 64'(digit_valid[5]), 64'd0);
    PAO = 8'h06;
    tick(3);
    chk("d5_early_ft", 64'(frame_tick), 64'd0);
    tick(1);
    chk("d5_seg", 64'(digits[41:35]), 64'h06);
    chk("d5_ft", 64'(frame_tick), 64'd1);
    PBO = 8'h0A;
    tick(1);
    chk("d5_ft_pulse", 64'(frame_tick), 64'd0);
    tick(2);
    PBO = 8'h1E;
    tick(1);
    chk("short_hold_v1", 64'(digit_valid[1]), 64'd0);
    PBO = 8'h0C; PAO = 8'h5B;
    tick(4);
    chk("to_latch_v2", 64'(digit_valid[2]), 64'd1);
    PBO = 8'h1E;
    tick(30);
    chk("to_alive_v2", 64'(digit_valid[2]), 64'd1);
    tick(1);
    chk("to_expire_v2", 64'(digit_valid[2]), 64'd0);
    chk("to_expire_d2", 64'(digits[20:14]), 64'd0);
    PBO = 8'h0C;
    tick(4);
    PBO = 8'h1E;
    tick(27);
    PBO = 8'h0C;
    tick(3);
    chk("refresh_pre_v2", 64'(digit_valid[2]), 64'd1);
    tick(1);
    chk("refresh_v2", 64'(digit_valid[2]), 64'd1);
    chk("refresh_d2", 64'(digits[20:14]), 64'h5B);
    PBO = 8'h1E;
    tick(30);
    chk("refresh_alive_v2", 64'(digit_valid[2]), 64'd1);
    tick(1);
    chk("refresh_expire_v2", 64'(digit_valid[2]), 64'd0);
    key_raw[9] = 1'b1;
    tick(4);
    chk("key9_early", 64'(key_db[9]), 64'd0);
    tick(1);
    chk("key9_db", 64'(key_db[9]), 64'd1);
    PBO = 8'h02;
    #1 chk("pai_row1", 64'(PAI), 64'hFB);
    PBO = 8'h00;
    #1 chk("pai_row0", 64'(PAI), 64'hFF);
    key_raw[0] = 1'b1;
    tick(2);
    key_raw[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("glitch_key0", 64'(key_db[0]), 64'd0);
    end
    PBO = 8'h08; DDRB = 8'h1E; PAO = 8'h3F;
    tick(2);
    DDRB = 8'h1C;
    tick(3);
    chk("dir_early_v1", 64'(digit_valid[1]), 64'd0);
    tick(1);
    chk("dir_d1", 64'(digits[13:7]), 64'h3F);
    chk("dir_v1", 64'(digit_valid[1]), 64'd1);
    chk("dir_v0", 64'(digit_valid[0]), 64'd0);
    hold = 0;
    for (int i = 0; i < 700; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 7);
        PBO  = 8'($urandom);
        DDRB = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h1E;
        DDRA = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
        PAO  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : seg_tab[$urandom_range(0, 5)];
      end
      hold--;
      if ($urandom_range(0, 3) == 0) begin
        kb = $urandom_range(0, 20);
        key_raw[kb] = ~key_raw[kb];
      end
      tick(1);
    end
    PBO = 8'h0E; DDRB = 8'h1E; DDRA = 8'hFF; PAO = 8'h7F; key_raw = 21'h000200;
    tick(8);
    chk("pre_rst_v3", 64'(digit_valid[3]), 64'd1);
    chk("pre_rst_key9", 64'(key_db[9]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", 64'(digits), 64'd0);
    chk("mid_rst_valid", 64'(digit_valid), 64'd0);
    chk("mid_rst_key_db", 64'(key_db), 64'd0);
    chk("mid_rst_pai", 64'(PAI), 64'hFF);
    @(negedge phi2);
    rst_n = 1'b1;
    PBO = 8'h12; PAO = 8'h06;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("post_rst_ft", 64'(frame_tick), 64'd0);
    end
    tick(1);
    chk("post_rst_d5_ft", 64'(frame_tick), 64'd1);
    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
